i2c_tx_sequencer: RTL and testbench
===================================

I2C_TX_SEQUENCER -- requirements
Module: i2c_tx_sequencer

Interface
REQ-001 Parameter: DATA_W, default 8, meaning bits per transmitted byte; only 8 is supported.
REQ-002 clk  input  1  system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 scl_rise  input  1  one-cycle strobe, synchronized SCL rising edge.
REQ-005 scl_fall  input  1  one-cycle strobe, synchronized SCL falling edge.
REQ-006 sda_in  input  1  synchronized SDA line level.
REQ-007 start_tx  input  1  one-cycle strobe from the address decoder: read transfer granted; SCL is low.
REQ-008 stop_seen  input  1  one-cycle strobe: STOP or repeated START detected on the bus.
REQ-009 data_in  input  8  byte offered by the register file.
REQ-010 data_valid  input  1  data_in valid; forms a handshake with data_req.
REQ-011 data_req  output  1  request for the next byte; held until data_valid is sampled high.
REQ-012 sda_oe  output  1  open-drain pull-low enable; 1 drives SDA low.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 nack_pulse  output  1  one-cycle pulse when the master NACKs a byte.
REQ-015 underrun  output  1  sticky flag: a byte was needed before data_valid arrived; cleared by start_tx.
REQ-016 byte_count  output  8  bytes completed and ACKed in the current transfer.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, ACK_WAIT and ACK_HOLD.
REQ-018 In IDLE, start_tx SHALL move the FSM to LOAD, assert data_req, clear byte_count and clear underrun.
REQ-019 In LOAD, data_valid=1 SHALL load data_in into the shift register, clear the bit counter, drop data_req and enter SHIFT on the next cycle.
REQ-020 In LOAD, an scl_rise with data_valid=0 SHALL load 0xFF, set underrun, drop data_req and enter SHIFT.
REQ-021 In SHIFT, sda_oe SHALL equal the inverse of shift register bit 7, combinational from the register.
REQ-022 In SHIFT, each scl_fall SHALL shift the register left by one (zero fill) and increment the 3-bit bit counter.
REQ-023 The scl_fall at bit counter 7 SHALL release SDA (sda_oe=0) and enter ACK_WAIT.
REQ-024 In ACK_WAIT, scl_rise with sda_in=0 SHALL increment byte_count (wrapping 255 to 0) and enter ACK_HOLD.
REQ-025 In ACK_WAIT, scl_rise with sda_in=1 SHALL pulse nack_pulse for one cycle and return to IDLE.
REQ-026 In ACK_HOLD, scl_fall SHALL enter LOAD and assert data_req in the same cycle.
REQ-027 stop_seen in any state SHALL force IDLE, sda_oe=0 and data_req=0 on the next edge; stop_seen takes priority over all simultaneous strobes.
REQ-028 start_tx outside IDLE SHALL be ignored.
REQ-029 scl_rise and scl_fall asserted in the same cycle SHALL be treated as a protocol error: no state change.
REQ-030 sda_oe SHALL be 0 in IDLE, LOAD, ACK_WAIT and ACK_HOLD.

Reset
REQ-031 Asserting reset (low) SHALL immediately force IDLE with sda_oe=0, busy=0, data_req=0, nack_pulse=0, underrun=0, byte_count=0, shift register=0x00 and bit counter=0.
REQ-032 Reset asserted mid-byte SHALL release SDA within the same cycle, with no further clock edge required.
REQ-033 Deassertion of reset SHALL only be acted on at a clk edge; the first cycle after deassertion is IDLE.

Structure
REQ-034 State encodings and the DATA_W constant SHALL live in the shared package i2c_pkg.
REQ-035 The shift register and bit counter SHALL be one sub-module, i2c_tx_shifter, with inputs load, shift and load_data and outputs msb and last_bit.
REQ-036 The FSM, handshake and counters SHALL stay in i2c_tx_sequencer.

Verification
REQ-037 Scenario: start_tx, then data_valid with data_in=0xA5, then 8 SCL periods -> sda_oe sequence 0,1,0,1,1,0,1,0 sampled at scl_rise, and SDA released at the 8th scl_fall.
REQ-038 Scenario: bytes 0x3C and 0xFF, master ACKs the first and NACKs the second -> byte_count=1, one nack_pulse, FSM in IDLE, data_req asserted exactly twice.
REQ-039 Scenario: start_tx with data_valid held low through the first scl_rise -> underrun=1, byte 0xFF shifted (sda_oe=0 for all 8 bits).
REQ-040 Scenario: stop_seen at bit 4 of 0x00 (sda_oe=1) -> sda_oe=0 and busy=0 on the next cycle, with no nack_pulse.
REQ-041 Scenario: reset driven low at bit 2 between clk edges -> sda_oe=0 immediately, and all outputs at reset values.
REQ-042 Scenario: 256 consecutive ACKed bytes -> byte_count wraps to 0, with no missed data_req.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants and state encoding for the I2C slave transmit path.
//   DATA_W  - bits per transmitted byte (only 8 is supported)
//   CNT_W   - width of the bit counter inside the shifter
//   state_e - sequencer FSM states
package i2c_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_ACK_WAIT,
      ST_ACK_HOLD
   } state_e;

endpackage

// File: rtl/i2c_tx_shifter.sv
// i2c_tx_shifter: MSB-first transmit shift register with its bit counter.
//   clk, reset (async, active-low)
//   load      - capture load_data and clear the bit counter (wins over shift)
//   shift     - shift left by one with zero fill, increment the bit counter
//   load_data - byte to transmit
//   msb       - current bit on the wire (register bit 7)
//   last_bit  - bit counter is at the final bit of the byte
module i2c_tx_shifter #(
   parameter int unsigned DATA_W = i2c_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic              msb,
   output logic              last_bit
);
   import i2c_pkg::*;

   logic [DATA_W-1:0] sreg_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         sreg_q <= load_data;
         cnt_q  <= '0;
      end else if (shift) begin
         sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

   assign msb      = sreg_q[DATA_W-1];
   assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer: I2C slave read-data sequencer. Fetches bytes from the
// register file, shifts them onto SDA (open-drain) and tracks master ACK/NACK.
//   clk, reset   - system clock; async active-low reset
//   scl_rise/fall- synchronized SCL edge strobes
//   sda_in       - synchronized SDA level (master ACK/NACK)
//   start_tx     - read transfer granted (SCL low); honoured only in IDLE
//   stop_seen    - STOP / repeated START; aborts to IDLE from any state
//   data_in/data_valid/data_req - byte fetch handshake
//   sda_oe       - 1 pulls SDA low
//   busy         - FSM not in IDLE
//   nack_pulse   - one cycle when the master NACKs a byte
//   underrun     - sticky: byte needed before data_valid; cleared by start_tx
//   byte_count   - bytes ACKed in the current transfer (wraps)
module i2c_tx_sequencer #(
   parameter int unsigned DATA_W = i2c_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_rise,
   input  logic              scl_fall,
   input  logic              sda_in,
   input  logic              start_tx,
   input  logic              stop_seen,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_req,
   output logic              sda_oe,
   output logic              busy,
   output logic              nack_pulse,
   output logic              underrun,
   output logic [7:0]        byte_count
);
   import i2c_pkg::*;

   state_e            state_q, state_d;
   logic              data_req_q, data_req_d;
   logic              nack_q, nack_d;
   logic              underrun_q, underrun_d;
   logic [7:0]        byte_count_q, byte_count_d;

   logic              sh_load, sh_shift;
   logic [DATA_W-1:0] sh_data;
   logic              sh_msb, sh_last;

   // Both SCL strobes in one cycle is a protocol error: neither edge is acted on.
   logic rise, fall;
   assign rise = scl_rise & ~scl_fall;
   assign fall = scl_fall & ~scl_rise;

   i2c_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (sh_load),
      .shift     (sh_shift),
      .load_data (sh_data),
      .msb       (sh_msb),
      .last_bit  (sh_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         data_req_q   <= 1'b0;
         nack_q       <= 1'b0;
         underrun_q   <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         data_req_q   <= data_req_d;
         nack_q       <= nack_d;
         underrun_q   <= underrun_d;
         byte_count_q <= byte_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      data_req_d   = data_req_q;
      nack_d       = 1'b0;
      underrun_d   = underrun_q;
      byte_count_d = byte_count_q;
      sh_load      = 1'b0;
      sh_shift     = 1'b0;
      sh_data      = data_in;

      if (stop_seen) begin
         state_d    = ST_IDLE;
         data_req_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_tx) begin
                  state_d      = ST_LOAD;
                  data_req_d   = 1'b1;
                  byte_count_d = '0;
                  underrun_d   = 1'b0;
               end
            end
            ST_LOAD: begin
               if (data_valid) begin
                  sh_load    = 1'b1;
                  data_req_d = 1'b0;
                  state_d    = ST_SHIFT;
               end else if (rise) begin
                  // Master is already clocking the first bit: send all-ones.
                  sh_load    = 1'b1;
                  sh_data    = '1;
                  underrun_d = 1'b1;
                  data_req_d = 1'b0;
                  state_d    = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (fall) begin
                  sh_shift = 1'b1;
                  if (sh_last) state_d = ST_ACK_WAIT;
               end
            end
            ST_ACK_WAIT: begin
               if (rise) begin
                  if (!sda_in) begin
                     byte_count_d = byte_count_q + 8'd1;
                     state_d      = ST_ACK_HOLD;
                  end else begin
                     nack_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_ACK_HOLD: begin
               if (fall) begin
                  state_d    = ST_LOAD;
                  data_req_d = 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               data_req_d = 1'b0;
            end
         endcase
      end
   end

   // Derived from the state register so an async reset releases SDA at once.
   assign sda_oe     = (state_q == ST_SHIFT) & ~sh_msb;
   assign busy       = (state_q != ST_IDLE);
   assign data_req   = data_req_q;
   assign nack_pulse = nack_q;
   assign underrun   = underrun_q;
   assign byte_count = byte_count_q;

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// tb_i2c_tx_sequencer: directed + randomized bench for i2c_tx_sequencer.
// Expected SDA drive is taken from the transmitted byte's bits (MSB first,
// drive low for a 0), byte_count from a plain integer count of ACKs.
module tb_i2c_tx_sequencer;

   localparam int P_RISE  = 0;
   localparam int P_FALL  = 1;
   localparam int P_BOTH  = 2;
   localparam int P_START = 3;
   localparam int P_STOP  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       scl_rise = 1'b0;
   logic       scl_fall = 1'b0;
   logic       sda_in = 1'b1;
   logic       start_tx = 1'b0;
   logic       stop_seen = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_req, sda_oe, busy, nack_pulse, underrun;
   logic [7:0] byte_count;

   int vectors = 0;
   int miscompares = 0;
   int req_edges = 0;
   int nacks = 0;
   int exp_count = 0;

   i2c_tx_sequencer #(.DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .scl_rise   (scl_rise),
      .scl_fall   (scl_fall),
      .sda_in     (sda_in),
      .start_tx   (start_tx),
      .stop_seen  (stop_seen),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_req   (data_req),
      .sda_oe     (sda_oe),
      .busy       (busy),
      .nack_pulse (nack_pulse),
      .underrun   (underrun),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   always @(posedge data_req) req_edges++;
   always @(posedge clk) if (nack_pulse === 1'b1) nacks++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int which);
      case (which)
         P_RISE:  scl_rise = 1'b1;
         P_FALL:  scl_fall = 1'b1;
         P_BOTH:  begin scl_rise = 1'b1; scl_fall = 1'b1; end
         P_START: start_tx = 1'b1;
         P_STOP:  stop_seen = 1'b1;
         default: ;
      endcase
      cyc(1);
      scl_rise  = 1'b0;
      scl_fall  = 1'b0;
      start_tx  = 1'b0;
      stop_seen = 1'b0;
   endtask

   task automatic serve(input logic [7:0] b);
      int t = 0;
      while (data_req !== 1'b1 && t < 20) begin
         cyc(1);
         t++;
      end
      chk("req_seen", data_req, 1);
      data_in    = b;
      data_valid = 1'b1;
      cyc(1);
      data_valid = 1'b0;
      chk("req_drop", data_req, 0);
      chk("busy_loaded", busy, 1);
   endtask

   // err_at < 8 injects a simultaneous rise+fall and a stray start_tx at that bit.
   task automatic send_byte(input logic [7:0] b, input bit ack, input int err_at);
      logic [7:0] v = b;
      for (int i = 0; i < 8; i++) begin
         cyc(int'($urandom_range(0, 1)));
         chk("bit", sda_oe, !v[7-i]);
         pulse(P_RISE);
         if (i == err_at) begin
            pulse(P_BOTH);
            pulse(P_START);
            chk("bit_hold", sda_oe, !v[7-i]);
         end
         pulse(P_FALL);
      end
      chk("sda_release", sda_oe, 0);
      chk("busy_ackwait", busy, 1);
      sda_in = ack ? 1'b0 : 1'b1;
      pulse(P_RISE);
      sda_in = 1'b1;
      if (ack) begin
         exp_count = (exp_count + 1) % 256;
         chk("byte_count", byte_count, exp_count);
         chk("no_nack", nack_pulse, 0);
         chk("sda_ackhold", sda_oe, 0);
         pulse(P_FALL);
         chk("req_after_ack", data_req, 1);
      end else begin
         chk("nack_pulse", nack_pulse, 1);
         chk("idle_after_nack", busy, 0);
         chk("byte_count_nack", byte_count, exp_count);
         cyc(1);
         chk("nack_one_cycle", nack_pulse, 0);
      end
   endtask

   initial begin
      logic [7:0] b;
      int n;

      // Reset values while reset is held low.
      #3;
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data_req", data_req, 0);
      chk("rst_nack", nack_pulse, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_byte_count", byte_count, 0);
      #19 reset = 1'b1;
      cyc(1);
      chk("idle_after_rst", busy, 0);

      // 0xA5 single byte, NACKed.
      exp_count = 0;
      req_edges = 0;
      pulse(P_START);
      chk("req_on_start", data_req, 1);
      chk("busy_on_start", busy, 1);
      serve(8'hA5);
      send_byte(8'hA5, 1'b0, 8);
      chk("a5_req_edges", req_edges, 1);

      // 0x3C ACKed (with protocol-error and stray start injected), 0xFF NACKed.
      exp_count = 0;
      req_edges = 0;
      nacks = 0;
      pulse(P_START);
      serve(8'h3C);
      send_byte(8'h3C, 1'b1, 3);
      serve(8'hFF);
      send_byte(8'hFF, 1'b0, 8);
      chk("two_byte_count", byte_count, 1);
      chk("two_nacks", nacks, 1);
      chk("two_idle", busy, 0);
      chk("two_req_edges", req_edges, 2);

      // Underrun: no data before the first SCL rise.
      pulse(P_START);
      chk("ur_req", data_req, 1);
      cyc(2);
      pulse(P_RISE);
      chk("ur_flag", underrun, 1);
      chk("ur_req_drop", data_req, 0);
      chk("ur_busy", busy, 1);
      pulse(P_FALL);
      for (int i = 1; i < 8; i++) begin
         chk("ur_bit", sda_oe, 0);
         pulse(P_RISE);
         pulse(P_FALL);
      end
      chk("ur_release", sda_oe, 0);
      chk("ur_ackwait", busy, 1);
      sda_in = 1'b0;
      pulse(P_RISE);
      sda_in = 1'b1;
      chk("ur_count", byte_count, 1);
      pulse(P_FALL);
      pulse(P_STOP);
      chk("ur_stop_idle", busy, 0);
      chk("ur_stop_req", data_req, 0);
      chk("ur_sticky", underrun, 1);
      pulse(P_START);
      chk("ur_cleared", underrun, 0);
      chk("ur_count_clr", byte_count, 0);
      pulse(P_STOP);
      chk("ur_idle2", busy, 0);

      // STOP at bit 4 of 0x00.
      pulse(P_START);
      serve(8'h00);
      for (int i = 0; i < 4; i++) begin
         chk("stop_bit", sda_oe, 1);
         pulse(P_RISE);
         pulse(P_FALL);
      end
      chk("stop_pre", sda_oe, 1);
      pulse(P_STOP);
      chk("stop_sda", sda_oe, 0);
      chk("stop_busy", busy, 0);
      chk("stop_req", data_req, 0);
      chk("stop_nack", nack_pulse, 0);
      cyc(1);
      chk("stop_nack2", nack_pulse, 0);

      // Async reset at bit 2 of the second byte.
      exp_count = 0;
      pulse(P_START);
      b = 8'($urandom);
      serve(b);
      send_byte(b, 1'b1, 8);
      serve(8'h00);
      for (int i = 0; i < 2; i++) begin
         pulse(P_RISE);
         pulse(P_FALL);
      end
      chk("mid_pre", sda_oe, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_sda", sda_oe, 0);
      chk("mid_busy", busy, 0);
      chk("mid_req", data_req, 0);
      chk("mid_nack", nack_pulse, 0);
      chk("mid_underrun", underrun, 0);
      chk("mid_count", byte_count, 0);
      #1 reset = 1'b1;
      cyc(1);
      chk("mid_idle", busy, 0);
      chk("mid_sda2", sda_oe, 0);

      // 256 ACKed random bytes: count wraps, every byte requested.
      exp_count = 0;
      req_edges = 0;
      pulse(P_START);
      for (int k = 0; k < 256; k++) begin
         b = 8'($urandom);
         serve(b);
         send_byte(b, 1'b1, 8);
         chk("wrap_req_edges", req_edges, k + 2);
      end
      chk("wrap_count", byte_count, 0);
      pulse(P_STOP);
      chk("wrap_idle", busy, 0);

      // Short random transfer ending in NACK.
      exp_count = 0;
      n = int'($urandom_range(1, 4));
      pulse(P_START);
      for (int j = 0; j < n; j++) begin
         b = 8'($urandom);
         serve(b);
         send_byte(b, (j != n - 1), 8);
      end
      chk("rand_count", byte_count, n - 1);
      chk("rand_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
